// File: rtl/dword_to_word_splitter_pkg.sv
// rtl/dword_to_word_splitter_pkg.sv - shared types and widths for the 64-to-32 narrowing gearbox
package dword_to_word_splitter_pkg;

  // Beat width shared with the 32-to-64 widening path
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2
  } state_t;

endpackage

// File: rtl/dword_to_word_splitter.sv
// rtl/dword_to_word_splitter.sv - splits 2*DATA_W words into two DATA_W beats, low half first
// Optional: SKIP_ZERO_UPPER_EN emits words with a zero upper half as a single beat.
module dword_to_word_splitter
  import dword_to_word_splitter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready
);

  state_t              state, state_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic                last_q, last_d;
  logic                accept;
  logic                single_d;

`ifdef SKIP_ZERO_UPPER_EN
  logic upper_zero;
  assign upper_zero = (data_q[2*DATA_W-1:DATA_W] == '0);
`endif

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state == ST_EMPTY) || ((state == ST_HI) && out_ready);
`ifdef SKIP_ZERO_UPPER_EN
      if ((state == ST_LO) && out_ready && upper_zero) in_ready = 1'b1;
`endif
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state)
      ST_EMPTY: if (accept) state_d = ST_LO;
      ST_LO: begin
        if (out_ready) begin
`ifdef SKIP_ZERO_UPPER_EN
          if (upper_zero) state_d = accept ? ST_LO : ST_EMPTY;
          else            state_d = ST_HI;
`else
          state_d = ST_HI;
`endif
        end
      end
      ST_HI: if (out_ready) state_d = accept ? ST_LO : ST_EMPTY;
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      data_d = in_data;
      last_d = in_last;
    end
  end

  // True when the beat that will be presented next completes its word in LO
`ifdef SKIP_ZERO_UPPER_EN
  assign single_d = (state_d == ST_LO) && (data_d[2*DATA_W-1:DATA_W] == '0);
`else
  assign single_d = 1'b0;
`endif

  // Outputs are registered from the next-state view so nothing on in_* reaches out_* combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      data_q    <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      data_q    <= data_d;
      last_q    <= last_d;
      out_valid <= (state_d != ST_EMPTY);
      out_last  <= last_d && ((state_d == ST_HI) || single_d);
      unique case (state_d)
        ST_LO:   out_data <= data_d[DATA_W-1:0];
        ST_HI:   out_data <= data_d[2*DATA_W-1:DATA_W];
        default: out_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dword_to_word_splitter.sv
// tb/tb_dword_to_word_splitter.sv - self-checking bench for dword_to_word_splitter
module tb_dword_to_word_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SKIP_ZERO_UPPER_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  always #5 clk = ~clk;

  dword_to_word_splitter #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic drive(input logic v, input logic [63:0] d, input logic l, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++;
    if ({out_valid, out_last, out_data} !== 34'h0) begin
      n_fail++; $display("FAIL reset_outputs got v=%b l=%b d=%h want all 0", out_valid, out_last, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    drive(1'b1, 64'h1122_3344_5566_7788, 1'b1, 1'b1);
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'h5566_7788}) begin
      n_fail++; $display("FAIL basic_lo got v=%b l=%b d=%h want v=1 l=0 d=55667788", out_valid, out_last, out_data);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 32'h1122_3344}) begin
      n_fail++; $display("FAIL basic_hi got v=%b l=%b d=%h want v=1 l=1 d=11223344", out_valid, out_last, out_data);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] words [4];
    logic [31:0] exp_beats [8];
    int idx = 0;
    for (int i = 0; i < 4; i++) begin
      words[i] = {32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i)};
      exp_beats[2*i]   = words[i][31:0];
      exp_beats[2*i+1] = words[i][63:32];
    end
    for (int c = 0; c < 10; c++) begin
      drive(idx < 4, (idx < 4) ? words[idx] : 64'h0, idx == 3, 1'b1);
      if (c < 8) begin
        n_checks++;
        if (in_ready !== ((c % 2) == 0)) begin
          n_fail++; $display("FAIL b2b_in_ready cycle %0d got %b want %b", c, in_ready, (c % 2) == 0);
        end
      end
      if (c >= 1 && c <= 8) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_beats[c-1]) begin
          n_fail++; $display("FAIL b2b_beat %0d got v=%b d=%h want v=1 d=%h", c - 1, out_valid, out_data, exp_beats[c-1]);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle out_valid got %b want 0", out_valid); end
      end
      if (in_valid && in_ready) idx++;
    end
  endtask

  task automatic test_stall;
    drive(1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 64'hCAFE_0000_F00D_0000, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h5566_7788 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall cycle %0d got v=%b d=%h rdy=%b want v=1 d=55667788 rdy=0", c, out_valid, out_data, in_ready);
      end
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1122_3344 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got v=%b l=%b d=%h want v=1 l=0 d=11223344", out_valid, out_last, out_data);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 64'h1357_9BDF_2468_ACE0, 1'b1, 1'b1);
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_data !== 32'h1357_9BDF || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hi got d=%h rdy=%b want d=13579bdf rdy=0", out_data, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_last, out_data} !== 34'h0) begin
      n_fail++; $display("FAIL rstmid_cleared got v=%b l=%b d=%h want all 0", out_valid, out_last, out_data);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_hi out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_zero_upper;
    drive(1'b1, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b1);
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_last !== SKIP) begin
      n_fail++; $display("FAIL zero_upper_lo got v=%b l=%b d=%h want v=1 l=%b d=deadbeef", out_valid, out_last, out_data, SKIP);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    n_checks++;
    if (SKIP) begin
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_upper_single out_valid got %b want 0", out_valid); end
    end else begin
      if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 32'h0}) begin
        n_fail++; $display("FAIL zero_upper_hi got v=%b l=%b d=%h want v=1 l=1 d=0", out_valid, out_last, out_data);
      end
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic [32:0] exp_q [$];
    logic [32:0] exp;
    logic [31:0] lo, hi;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;
    int words_sent = 0;
    int cyc = 0;
    while ((words_sent < 10000 || exp_q.size() != 0) && cyc < 80000) begin
      lo = $urandom;
      hi = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      drive((words_sent < 10000) && ($urandom_range(0, 3) != 0), {hi, lo},
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== prev_beat) begin
          n_fail++; $display("FAIL rand_stable got v=%b beat=%h want v=1 beat=%h", out_valid, {out_last, out_data}, prev_beat);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra_beat got %h want no beat", {out_last, out_data});
        end else begin
          exp = exp_q.pop_front();
          if ({out_last, out_data} !== exp) begin
            n_fail++; $display("FAIL rand_beat got l=%b d=%h want l=%b d=%h", out_last, out_data, exp[32], exp[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (SKIP && in_data[63:32] == 32'h0) begin
          exp_q.push_back({in_last, in_data[31:0]});
        end else begin
          exp_q.push_back({1'b0, in_data[31:0]});
          exp_q.push_back({in_last, in_data[63:32]});
        end
        words_sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_data};
      cyc++;
    end
    n_checks++;
    if (cyc >= 80000) begin
      n_fail++; $display("FAIL rand_timeout words %0d pending %0d want 10000 and 0", words_sent, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_zero_upper();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dword_to_word_splitter.md
Name: dword_to_word_splitter

Overview:
- Narrowing gearbox: accepts 64-bit words on a valid/ready stream and emits them as two 32-bit beats, low half first.
- Inverse of the 32-to-64 left-pad widening path. Sits between 64-bit datapath results (eBPF CPU registers, DRAM DMA read data) and 32-bit consumers (register/status interfaces).
- Registered output with full back-pressure. Sustains one 32-bit beat per cycle.

Parameters:
- DATA_W, 32, output beat width; input word width is fixed at 2*DATA_W.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  2*DATA_W  input word.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  word is the final word of a packet.
- in_ready  output  1  splitter accepts the word this cycle.
- out_data  output  DATA_W  output beat.
- out_valid  output  1  out_data/out_last valid.
- out_last  output  1  beat is the final beat of a packet.
- out_ready  input  1  downstream accepts the beat this cycle.

Behaviour:
- State: data_q[2*DATA_W-1:0], last_q, and a 2-state-plus-idle FSM with states EMPTY, LO and HI.
- Reset (rst=1 at the clock edge):
  - state=EMPTY; data_q=0; last_q=0.
  - out_valid=0, out_data=0, out_last=0.
  - in_ready is forced 0 while rst=1.
  - A held word is discarded when reset arrives mid-word, with no partial completion.
- Outputs:
  - out_valid = (state != EMPTY).
  - out_data = data_q[DATA_W-1:0] in LO, data_q[2*DATA_W-1:DATA_W] in HI, 0 in EMPTY.
  - out_last = last_q && state==HI; 0 otherwise.
- in_ready = !rst && (state==EMPTY || (state==HI && out_ready)).
- Accept = in_valid && in_ready. On accept: load data_q and last_q, and go to LO.
- Transitions:
  - EMPTY: on accept go to LO; else stay.
  - LO: on out_ready go to HI; else hold.
  - HI with out_ready and accept: go to LO with the new word. This is a back-to-back word with no bubble.
  - HI with out_ready and no accept: go to EMPTY.
  - HI without out_ready: hold.
- Latency: a word accepted at edge N gives its low beat at out_valid after edge N, and its high beat one cycle later if out_ready=1.
- Throughput: a continuous input with out_ready held high gives one beat per cycle, and in_ready is high every second cycle.
- Stability: while out_valid && !out_ready, out_data and out_last must hold constant.
- in_valid must not be used to generate out_valid combinationally. There is no combinational path from in_* to out_*.
- out_ready to in_ready is a combinational path, and it is permitted.
- in_last is a single flag per word; it is never split across beats.

Optional Feature:
- Macro: SKIP_ZERO_UPPER_EN.
- Defined:
  - In LO, when data_q[2*DATA_W-1:DATA_W]==0, the word is emitted as a single beat.
  - out_last = last_q in that LO beat.
  - On out_ready, go to LO if accept, else EMPTY.
  - in_ready additionally asserts in LO with out_ready and a zero upper half.
  - This strips the zero padding added by the widening path.
- Undefined: every word always produces exactly two beats; the behaviour above applies unchanged.

Decomposition:
- Shared package holds:
  - State enum (ST_EMPTY, ST_LO, ST_HI) as a 2-bit typedef.
  - DATA_W default constant, shared with the widening path.
- No sub-module. A single FSM with a holding register is the natural boundary. The stream-handshake checker belongs in the bench, not the RTL.

Test Plan:
- Reset, then in_data=64'h1122_3344_5566_7788, in_last=1, out_ready=1: beats 32'h5566_7788 (last=0), then 32'h1122_3344 (last=1); then out_valid=0.
- Four back-to-back words with in_valid and out_ready held high: 8 beats on consecutive cycles with no bubble; in_ready pattern 1,0,1,0…
- out_ready held low for 5 cycles while in LO: out_data stays 32'h5566_7788, and in_ready=0 throughout.
- rst asserted while in HI: next cycle out_valid=0 and out_data=0; the remaining high beat is never emitted.
- With SKIP_ZERO_UPPER_EN, in_data=64'h0000_0000_DEAD_BEEF and in_last=1: a single beat 32'hDEAD_BEEF with last=1.
- Without the macro, the same word gives 32'hDEAD_BEEF then 32'h0000_0000 (last=1).
- Random valid and ready toggling over 10k words: output equals the scoreboard low/high sequence; no beat is lost or duplicated.
